// File: rtl/token_run_checker_if.sv
// Run-record output handshake of the token run checker.
// Master drives the FIFO head; slave is the downstream consumer.
interface token_run_checker_if #(
  parameter int LEN_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [LEN_W-1:0] out_len;
  logic             out_odd;

  modport master (
    output out_valid,
    output out_len,
    output out_odd,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_len,
    input  out_odd,
    output out_ready
  );
endinterface

// File: rtl/token_run_checker.sv
// Measures runs of '1' on the doubled token stream and queues
// {len/2, odd} records in a first-word-fall-through FIFO.
module token_run_checker #(
  parameter int MAX_RUN = 400,
  parameter int LEN_W   = 8,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                b_in,
  token_run_checker_if.master rec,
  output logic                overflow,
  output logic                drop
);
  localparam int CNT_W = $clog2(MAX_RUN + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             odd;
  } rec_t;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  rec_t             mem [DEPTH];
  rec_t             head;
  rec_t             new_rec;
  logic             empty;
  logic             full;
  logic             pop;
  logic             run_end;
  logic             push;
  logic             lost;
  logic             at_max;

  assign half   = cnt >> 1;
  assign at_max = (cnt == CNT_W'(MAX_RUN));

  // Extra pointer bit separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign pop     = !empty && rec.out_ready;
  assign run_end = !b_in && (cnt != '0) && !overflow;
  assign push    = run_end && (!full || pop);
  assign lost    = run_end && full && !pop;

  always_comb begin
    new_rec     = '0;
    new_rec.len = LEN_W'(half);
    new_rec.odd = cnt[0];
  end

  assign head = mem[rd_ptr[PTR_W-1:0]];

  assign rec.out_valid = !empty;
  assign rec.out_len   = empty ? '0 : head.len;
  assign rec.out_odd   = empty ? 1'b0 : head.odd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      overflow <= 1'b0;
      drop     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (b_in) begin
        if (at_max) overflow <= 1'b1;
        else        cnt      <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (lost) drop   <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= new_rec;
  end
endmodule

// File: tb/tb_token_run_checker.sv
// Directed bench for token_run_checker with a queue scoreboard
// that predicts every record, pop and sticky flag cycle by cycle.
module tb_token_run_checker;
  localparam int MAX_RUN = 400;
  localparam int LEN_W   = 8;
  localparam int DEPTH   = 4;

  typedef struct {
    int len;
    int odd;
  } exp_t;

  logic clk;
  logic rst;
  logic b_in;
  logic overflow;
  logic drop;

  token_run_checker_if #(.LEN_W(LEN_W)) rec_if ();

  token_run_checker #(
    .MAX_RUN(MAX_RUN),
    .LEN_W  (LEN_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .b_in    (b_in),
    .rec     (rec_if),
    .overflow(overflow),
    .drop    (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  int   mcnt;
  bit   mov;
  bit   mdrop;
  int   pops;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mcnt  = 0;
    mov   = 0;
    mdrop = 0;
  endtask

  task automatic chk_head();
    chk("out_valid", 32'(rec_if.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_len", 32'(rec_if.out_len), q[0].len);
      chk("out_odd", 32'(rec_if.out_odd), q[0].odd);
    end else begin
      chk("out_len_empty", 32'(rec_if.out_len), 0);
      chk("out_odd_empty", 32'(rec_if.out_odd), 0);
    end
  endtask

  // Called just after a rising edge; drives inputs for the next one.
  task automatic step(input logic b, input logic rdy);
    bit   pop_m;
    exp_t e;
    b_in             = b;
    rec_if.out_ready = rdy;
    chk_head();
    pop_m = (q.size() != 0) && rdy;
    @(posedge clk);
    #1;
    if (pop_m) begin
      void'(q.pop_front());
      pops++;
    end
    if (b) begin
      if (mcnt < MAX_RUN) mcnt++;
      else mov = 1;
    end else if (mcnt != 0) begin
      if (!mov) begin
        e.len = mcnt / 2;
        e.odd = mcnt % 2;
        if (q.size() < DEPTH) q.push_back(e);
        else mdrop = 1;
      end
      mcnt = 0;
    end
    chk("overflow", 32'(overflow), 32'(mov));
    chk("drop", 32'(drop), 32'(mdrop));
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, rdy);
    step(1'b0, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy);
  endtask

  task automatic do_reset();
    b_in             = 1'b0;
    rec_if.out_ready = 1'b0;
    rst              = 1'b1;
    #1;
    chk("rst_valid", 32'(rec_if.out_valid), 0);
    chk("rst_len", 32'(rec_if.out_len), 0);
    chk("rst_odd", 32'(rec_if.out_odd), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop", 32'(drop), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    rst              = 1'b1;
    b_in             = 1'b0;
    rec_if.out_ready = 1'b0;
    pops             = 0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Two doubled runs: 2 then 4 ones.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("t1_valid", 32'(rec_if.out_valid), 1);
    chk("t1_len", 32'(rec_if.out_len), 1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("t1b_len", 32'(rec_if.out_len), 2);
    idle(3, 1'b1);

    // Odd run.
    run(3, 1'b1);
    chk("odd_flag", 32'(rec_if.out_odd), 1);
    idle(2, 1'b1);

    // Longest legal run, then one too long.
    run(MAX_RUN, 1'b1);
    chk("max_len", 32'(rec_if.out_len), MAX_RUN / 2);
    idle(2, 1'b1);
    do_reset();
    run(MAX_RUN + 1, 1'b1);
    chk("ovf_set", 32'(overflow), 1);
    run(2, 1'b1);
    idle(3, 1'b1);
    chk("ovf_sticky", 32'(overflow), 1);
    do_reset();

    // Five runs with a stalled consumer: fifth is dropped.
    for (int i = 0; i < 5; i++) run(2, 1'b0);
    chk("drop_set", 32'(drop), 1);
    pops = 0;
    idle(7, 1'b1);
    chk("drain_pops", 32'(pops), DEPTH);
    do_reset();

    // Full FIFO, run ends on the same edge as a pop.
    for (int i = 0; i < DEPTH; i++) run(2, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("full_pop_drop", 32'(drop), 0);
    pops = 0;
    idle(6, 1'b1);
    chk("full_pop_drain", 32'(pops), DEPTH);

    // Async reset mid-run with records queued.
    run(2, 1'b0);
    run(2, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(rec_if.out_valid), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_drop", 32'(drop), 0);
    do_reset();
    pops = 0;
    run(2, 1'b1);
    idle(3, 1'b1);
    chk("arst_single", 32'(pops), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
